// File: rtl/tick_period_pkg.sv
// Shared types and helpers for the multi-channel tick-period meter.
package tick_period_pkg;

  typedef enum logic [1:0] {
    UNARMED,
    ARMED,
    STALLED
  } chan_state_t;

  // All-ones value of a counter of the given width (widths up to 64 supported)
  function automatic logic [63:0] max_time(input int unsigned width);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tick_period_channel.sv
// One tick channel: saturating elapsed-us counter, arm/stall FSM and registered
// period, period_valid and stalled outputs.
module tick_period_channel
  import tick_period_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STALL_US = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             us_strobe,
  input  logic             tick,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] MAX_TIME    = WIDTH'(max_time(WIDTH));
  localparam logic [WIDTH-1:0] STALL_LIMIT = WIDTH'(STALL_US);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  chan_state_t      state_q, state_d;
  logic [WIDTH-1:0] elapsed_q, elapsed_d, elapsed_now;
  logic [WIDTH-1:0] period_d;
  logic             period_valid_d;
  logic             stalled_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UNARMED;
      elapsed_q    <= '0;
      period       <= MAX_TIME;
      period_valid <= 1'b0;
      stalled      <= 1'b1;
    end else begin
      state_q      <= state_d;
      elapsed_q    <= elapsed_d;
      period       <= period_d;
      period_valid <= period_valid_d;
      stalled      <= stalled_d;
    end
  end

  // A tick in the threshold cycle is checked first so it wins over the stall;
  // re-arming from UNARMED or STALLED never reports the interval that spanned it.
  always_comb begin
    elapsed_now    = (us_strobe && (elapsed_q != MAX_TIME)) ? elapsed_q + ONE : elapsed_q;
    state_d        = state_q;
    elapsed_d      = elapsed_now;
    period_d       = period;
    period_valid_d = 1'b0;
    stalled_d      = stalled;

    if (clear) begin
      state_d   = UNARMED;
      elapsed_d = '0;
      period_d  = MAX_TIME;
      stalled_d = 1'b1;
    end else begin
      case (state_q)
        UNARMED, STALLED: begin
          if (tick) begin
            state_d   = ARMED;
            elapsed_d = '0;
            stalled_d = 1'b0;
          end
        end
        ARMED: begin
          if (tick) begin
            period_d       = elapsed_now;
            period_valid_d = 1'b1;
            elapsed_d      = '0;
          end else if (elapsed_q == STALL_LIMIT) begin
            state_d        = STALLED;
            period_d       = MAX_TIME;
            period_valid_d = 1'b1;
            stalled_d      = 1'b1;
          end
        end
        default: state_d = UNARMED;
      endcase
    end
  end

endmodule

// File: rtl/tick_period_meter.sv
// Multi-channel tick-period timer: shared microsecond prescaler and free-running
// micros counter feeding NUM_CH independent period-measurement channels.
module tick_period_meter
  import tick_period_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 32,
  parameter int TICKS_PER_US = 50,
  parameter int STALL_US     = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       tick,
  input  logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH*WIDTH-1:0] period,
  output logic [NUM_CH-1:0]       period_valid,
  output logic [NUM_CH-1:0]       stalled,
  output logic [WIDTH-1:0]        micros
);

  localparam int             PW       = $clog2(TICKS_PER_US);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICKS_PER_US - 1);
  localparam logic [PW-1:0]  PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] US_ONE = WIDTH'(1);

  logic [PW-1:0] prescale;
  logic          us_strobe;

  assign us_strobe = (prescale == PRE_LAST);

  // One strobe per TICKS_PER_US clocks; micros wraps naturally at 2^WIDTH
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      micros   <= '0;
    end else begin
      prescale <= us_strobe ? '0 : prescale + PRE_ONE;
      if (us_strobe) micros <= micros + US_ONE;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    tick_period_channel #(
      .WIDTH   (WIDTH),
      .STALL_US(STALL_US)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .us_strobe   (us_strobe),
      .tick        (tick[ch]),
      .clear       (clear[ch]),
      .period      (period[ch*WIDTH +: WIDTH]),
      .period_valid(period_valid[ch]),
      .stalled     (stalled[ch])
    );
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: three parameterisations share clock and reset;
// expected period_valid payloads are queued per channel and checked when pulses appear.
module tb_tick_period_meter;

  logic         clk;
  logic         reset;

  logic [3:0]   tick_a, clear_a, valid_a, stalled_a;
  logic [127:0] period_a;
  logic [31:0]  micros_a;

  logic [3:0]   tick_b, clear_b, valid_b, stalled_b;
  logic [127:0] period_b;
  logic [31:0]  micros_b;

  logic [3:0]   tick_c, clear_c, valid_c, stalled_c;
  logic [31:0]  period_c;
  logic [7:0]   micros_c;

  int compareCount = 0;
  int failCount    = 0;
  int cyc          = 0;

  // Expected {stalled, period} per pulse, indexed by dut*4 + channel
  logic [32:0] expQ[12][$];

  tick_period_meter u_dut_a (
    .clk(clk), .reset(reset), .tick(tick_a), .clear(clear_a),
    .period(period_a), .period_valid(valid_a), .stalled(stalled_a), .micros(micros_a)
  );

  tick_period_meter #(.STALL_US(10)) u_dut_b (
    .clk(clk), .reset(reset), .tick(tick_b), .clear(clear_b),
    .period(period_b), .period_valid(valid_b), .stalled(stalled_b), .micros(micros_b)
  );

  tick_period_meter #(.WIDTH(8), .STALL_US(200)) u_dut_c (
    .clk(clk), .reset(reset), .tick(tick_c), .clear(clear_c),
    .period(period_c), .period_valid(valid_c), .stalled(stalled_c), .micros(micros_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side cycle index: at a negedge it equals the index of the current cycle
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectPulse(input int d, input int ch, input logic stl, input logic [31:0] per);
    expQ[d*4+ch].push_back({stl, per});
  endtask

  task automatic checkPulse(input int d, input int ch, input logic v, input logic [32:0] obs);
    logic [32:0] e;
    if (v) begin
      if (expQ[d*4+ch].size() == 0) begin
        checkOutput($sformatf("unexpected_valid_d%0d_ch%0d", d, ch), 64'(v), 64'd0);
      end else begin
        e = expQ[d*4+ch].pop_front();
        checkOutput($sformatf("pulse_d%0d_ch%0d", d, ch), 64'(obs), 64'(e));
      end
    end
  endtask

  task automatic checkQueuesEmpty(input string tag);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("%s_pending_q%0d", tag, i), 64'(expQ[i].size()), 64'd0);
  endtask

  // Drive tick/clear masks on one DUT for exactly one cycle
  task automatic applyStimulus(input int d, input logic [3:0] t, input logic [3:0] c);
    case (d)
      0: begin tick_a = t; clear_a = c; end
      1: begin tick_b = t; clear_b = c; end
      default: begin tick_c = t; clear_c = c; end
    endcase
    @(negedge clk);
    tick_a = '0; clear_a = '0;
    tick_b = '0; clear_b = '0;
    tick_c = '0; clear_c = '0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    for (int ch = 0; ch < 4; ch++) begin
      checkPulse(0, ch, valid_a[ch], {stalled_a[ch], period_a[ch*32 +: 32]});
      checkPulse(1, ch, valid_b[ch], {stalled_b[ch], period_b[ch*32 +: 32]});
      checkPulse(2, ch, valid_c[ch], {stalled_c[ch], 24'd0, period_c[ch*8 +: 8]});
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    tick_a = '0; clear_a = '0;
    tick_b = '0; clear_b = '0;
    tick_c = '0; clear_c = '0;
    waitCycles(3);

    $display("[TB] test 1: reset state and idle");
    for (int ch = 0; ch < 4; ch++)
      checkOutput($sformatf("rst_period_a%0d", ch), 64'(period_a[ch*32 +: 32]), 64'hFFFF_FFFF);
    checkOutput("rst_stalled_a", 64'(stalled_a), 64'hF);
    checkOutput("rst_valid_a", 64'(valid_a), 64'h0);
    checkOutput("rst_micros_b", 64'(micros_b), 64'h0);
    reset = 1'b0;
    waitCycles(1000);
    checkOutput("idle_micros_a", 64'(micros_a), 64'd20);
    checkOutput("idle_micros_c", 64'(micros_c), 64'd20);
    checkOutput("idle_stalled_a", 64'(stalled_a), 64'hF);
    for (int ch = 0; ch < 4; ch++)
      checkOutput($sformatf("idle_period_a%0d", ch), 64'(period_a[ch*32 +: 32]), 64'hFFFF_FFFF);

    $display("[TB] test 2: ch0 period 5000 clk");
    applyStimulus(0, 4'b0001, 4'b0000);
    checkOutput("arm_stalled_a0", 64'(stalled_a[0]), 64'd0);
    checkOutput("arm_period_a0", 64'(period_a[31:0]), 64'hFFFF_FFFF);
    for (int k = 0; k < 2; k++) begin
      waitCycles(4999);
      expectPulse(0, 0, 1'b0, 32'd100);
      applyStimulus(0, 4'b0001, 4'b0000);
      checkOutput($sformatf("meas%0d_period_a0", k), 64'(period_a[31:0]), 64'd100);
    end
    checkQueuesEmpty("t2");

    $display("[TB] test 3: ch1 and ch2 concurrent");
    for (int k = 0; k <= 15000; k++) begin
      logic [3:0] t;
      t = '0;
      if (k % 2500 == 0) t[1] = 1'b1;
      if (k % 7500 == 0) t[2] = 1'b1;
      if (k > 0 && t[1]) expectPulse(0, 1, 1'b0, 32'(2500 / 50));
      if (k > 0 && t[2]) expectPulse(0, 2, 1'b0, 32'(7500 / 50));
      applyStimulus(0, t, 4'b0000);
    end
    checkOutput("conc_period_a1", 64'(period_a[63:32]), 64'd50);
    checkOutput("conc_period_a2", 64'(period_a[95:64]), 64'd150);
    checkOutput("conc_period_a0", 64'(period_a[31:0]), 64'd100);
    checkOutput("conc_period_a3", 64'(period_a[127:96]), 64'hFFFF_FFFF);
    checkOutput("conc_stalled_a", 64'(stalled_a), 64'h8);
    checkQueuesEmpty("t3");

    $display("[TB] test 4: stall detection, STALL_US=10");
    applyStimulus(1, 4'b0001, 4'b0000);
    checkOutput("stl_arm_b0", 64'(stalled_b[0]), 64'd0);
    expectPulse(1, 0, 1'b1, 32'hFFFF_FFFF);
    waitCycles(600);
    checkOutput("stl_stalled_b0", 64'(stalled_b[0]), 64'd1);
    checkOutput("stl_period_b0", 64'(period_b[31:0]), 64'hFFFF_FFFF);
    applyStimulus(1, 4'b0001, 4'b0000);
    checkOutput("rearm_stalled_b0", 64'(stalled_b[0]), 64'd0);
    checkOutput("rearm_period_b0", 64'(period_b[31:0]), 64'hFFFF_FFFF);

    $display("[TB] test 5: clear priority and tick on threshold");
    waitCycles(99);
    expectPulse(1, 0, 1'b0, 32'd2);
    applyStimulus(1, 4'b0001, 4'b0000);
    checkOutput("short_period_b0", 64'(period_b[31:0]), 64'd2);
    applyStimulus(1, 4'b0001, 4'b0001);
    checkOutput("clr_period_b0", 64'(period_b[31:0]), 64'hFFFF_FFFF);
    checkOutput("clr_stalled_b0", 64'(stalled_b[0]), 64'd1);
    guard = 0;
    while ((cyc % 50) != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    applyStimulus(1, 4'b0010, 4'b0000);
    waitCycles(499);
    expectPulse(1, 1, 1'b0, 32'd10);
    applyStimulus(1, 4'b0010, 4'b0000);
    checkOutput("thr_period_b1", 64'(period_b[63:32]), 64'd10);
    checkOutput("thr_stalled_b1", 64'(stalled_b[1]), 64'd0);
    expectPulse(1, 1, 1'b1, 32'hFFFF_FFFF);
    waitCycles(600);
    checkOutput("late_stalled_b1", 64'(stalled_b[1]), 64'd1);
    checkQueuesEmpty("t5");

    $display("[TB] test 6: WIDTH=8 wrap and reset mid-measurement");
    guard = 0;
    while (micros_c != 8'd255 && guard < 13000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("wrap_reach_c", 64'(micros_c), 64'd255);
    guard = 0;
    while (micros_c == 8'd255 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("wrap_micros_c", 64'(micros_c), 64'd0);
    applyStimulus(2, 4'b0001, 4'b0000);
    checkOutput("mid_arm_c0", 64'(stalled_c[0]), 64'd0);
    waitCycles(500);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_period_c", 64'(period_c), 64'hFFFF_FFFF);
    checkOutput("mid_rst_stalled_c", 64'(stalled_c), 64'hF);
    checkOutput("mid_rst_valid_c", 64'(valid_c), 64'h0);
    checkOutput("mid_rst_micros_c", 64'(micros_c), 64'h0);
    checkOutput("mid_rst_stalled_a", 64'(stalled_a), 64'hF);
    reset = 1'b0;
    applyStimulus(2, 4'b0001, 4'b0000);
    checkOutput("post_arm_period_c0", 64'(period_c[7:0]), 64'hFF);
    waitCycles(999);
    expectPulse(2, 0, 1'b0, 32'd20);
    applyStimulus(2, 4'b0001, 4'b0000);
    checkOutput("post_period_c0", 64'(period_c[7:0]), 64'd20);
    waitCycles(5);
    checkQueuesEmpty("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
